// File: rtl/piso_stream_serializer.sv
// Parallel-in/serial-out symbol serializer: DATA_W-bit words in, SYM_W-bit symbols out,
// with a one-word holding buffer so back-to-back words stream without a bubble.
module piso_stream_serializer #(
    parameter int DATA_W    = 16,
    parameter int SYM_W     = 2,
    parameter int MSB_FIRST = 1,
    localparam int NSYM     = DATA_W / SYM_W,
    localparam int CNT_W    = $clog2(NSYM + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CNT_W-1:0]  i_nsym,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [SYM_W-1:0]  o_data,
    output logic              o_last,
    output logic              o_done,
    output logic              o_busy
);

    localparam logic [0:0]       ST_IDLE  = 1'b0;
    localparam logic [0:0]       ST_SHIFT = 1'b1;
    localparam logic [CNT_W-1:0] NSYM_C   = CNT_W'(NSYM);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C   = CNT_W'(0);

    if ((DATA_W % SYM_W) != 0) begin : g_width_check
        $error("piso_stream_serializer: DATA_W must be a multiple of SYM_W");
    end

    // A zero or oversized request means "the whole word".
    function automatic logic [CNT_W-1:0] norm_nsym(input logic [CNT_W-1:0] n);
        logic [CNT_W-1:0] r;
        if ((n == ZERO_C) || (n > NSYM_C)) begin
            r = NSYM_C;
        end else begin
            r = n;
        end
        return r;
    endfunction

    logic [0:0]        state_r;
    logic [DATA_W-1:0] sr_word_r;
    logic [CNT_W-1:0]  sr_cnt_r;
    logic [DATA_W-1:0] hb_word_r;
    logic [CNT_W-1:0]  hb_cnt_r;
    logic              hb_full_r;
    logic              done_r;

    logic [0:0]        state_nx_s;
    logic [DATA_W-1:0] sr_word_nx_s;
    logic [CNT_W-1:0]  sr_cnt_nx_s;
    logic [DATA_W-1:0] hb_word_nx_s;
    logic [CNT_W-1:0]  hb_cnt_nx_s;
    logic              hb_full_nx_s;

    logic              sr_valid_s;
    logic              sym_acc_s;
    logic              last_acc_s;
    logic              in_acc_s;
    logic [SYM_W-1:0]  emit_sym_s;
    logic [DATA_W-1:0] sr_shift_s;

    // The emit end of the shift register depends on symbol order; the word shifts toward it.
    if (MSB_FIRST != 0) begin : g_msb_first
        assign emit_sym_s = sr_word_r[DATA_W-1 -: SYM_W];
        assign sr_shift_s = sr_word_r << SYM_W;
    end else begin : g_lsb_first
        assign emit_sym_s = sr_word_r[SYM_W-1:0];
        assign sr_shift_s = sr_word_r >> SYM_W;
    end

    assign sr_valid_s = (state_r == ST_SHIFT);
    assign sym_acc_s  = sr_valid_s & i_ready;
    assign last_acc_s = sym_acc_s & (sr_cnt_r == ONE_C);
    assign in_acc_s   = i_valid & o_ready;

    assign o_ready = ~hb_full_r & ~i_rst;
    assign o_valid = sr_valid_s;
    assign o_data  = sr_valid_s ? emit_sym_s : {SYM_W{1'b0}};
    assign o_last  = sr_valid_s & (sr_cnt_r == ONE_C);
    assign o_done  = done_r;
    assign o_busy  = sr_valid_s | hb_full_r;

    // Next-state for the shift register and holding buffer; HB refills SR before a new input does.
    always_comb begin
        state_nx_s   = state_r;
        sr_word_nx_s = sr_word_r;
        sr_cnt_nx_s  = sr_cnt_r;
        hb_word_nx_s = hb_word_r;
        hb_cnt_nx_s  = hb_cnt_r;
        hb_full_nx_s = hb_full_r;

        case (state_r)
            ST_IDLE, ST_SHIFT: begin
                if (!sr_valid_s || last_acc_s) begin
                    if (hb_full_r) begin
                        state_nx_s   = ST_SHIFT;
                        sr_word_nx_s = hb_word_r;
                        sr_cnt_nx_s  = hb_cnt_r;
                        hb_full_nx_s = 1'b0;
                    end else if (in_acc_s) begin
                        state_nx_s   = ST_SHIFT;
                        sr_word_nx_s = i_data;
                        sr_cnt_nx_s  = norm_nsym(i_nsym);
                    end else begin
                        state_nx_s   = ST_IDLE;
                        sr_cnt_nx_s  = ZERO_C;
                    end
                end else if (sym_acc_s) begin
                    sr_word_nx_s = sr_shift_s;
                    sr_cnt_nx_s  = sr_cnt_r - ONE_C;
                end else begin
                    sr_word_nx_s = sr_word_r;
                end

                // A word arriving while SR is still busy parks in the holding buffer.
                if (in_acc_s && sr_valid_s && !last_acc_s) begin
                    hb_word_nx_s = i_data;
                    hb_cnt_nx_s  = norm_nsym(i_nsym);
                    hb_full_nx_s = 1'b1;
                end else begin
                    hb_word_nx_s = hb_word_nx_s;
                end
            end
            default: begin
                state_nx_s   = ST_IDLE;
                sr_cnt_nx_s  = ZERO_C;
                hb_full_nx_s = 1'b0;
            end
        endcase
    end

    // Datapath and control registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r   <= ST_IDLE;
            sr_word_r <= {DATA_W{1'b0}};
            sr_cnt_r  <= ZERO_C;
            hb_word_r <= {DATA_W{1'b0}};
            hb_cnt_r  <= ZERO_C;
            hb_full_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            sr_word_r <= sr_word_nx_s;
            sr_cnt_r  <= sr_cnt_nx_s;
            hb_word_r <= hb_word_nx_s;
            hb_cnt_r  <= hb_cnt_nx_s;
            hb_full_r <= hb_full_nx_s;
            done_r    <= last_acc_s;
        end
    end

endmodule
